ld_search_bank: RTL and testbench
=================================

Name: ld_search_bank

Overview:
- Parametrised successor to the LD_Project compare/flag datapath.
- Stores up to DEPTH words of WIDTH bits written from the input bus.
- On command, scans the stored words against a key, one entry per clock.
- Reports greater/equal/less counts, the first-match index and done/busy status to the top-level LD logic.

Parameters:
WIDTH, 5, bit width of stored words and key
DEPTH, 8, number of storage entries (>=2)
CW, $clog2(DEPTH+1), width of count outputs (derived localparam, not overridable)
IW, $clog2(DEPTH), width of index outputs (derived localparam, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  command strobe, sampled only when busy=0
op  input  2  00 nop, 01 write, 10 search, 11 clear
inp  input  WIDTH  write data or search key
busy  output  1  search in progress
done  output  1  one-cycle pulse, search results valid
fill  output  CW  number of valid stored entries
full  output  1  fill==DEPTH
ovf  output  1  sticky, write attempted while full
gt_cnt  output  CW  entries > key (unsigned)
eq_cnt  output  CW  entries == key
lt_cnt  output  CW  entries < key
eq_found  output  1  at least one equal entry
eq_idx  output  IW  lowest index with entry == key
par_key  output  1  parity of key (feature only)
par_all  output  1  XOR of all valid entries' bits (feature only)

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; fill, ovf, busy, done and all result outputs go to 0. Memory contents are not reset.
- Reset wins over any command in the same cycle. Reset mid-search aborts the scan with no done pulse.
- Commands are accepted when start=1 and busy=0. start while busy=1 is ignored, not queued.
- WRITE, fill<DEPTH: mem[fill]<=inp and fill<=fill+1 at the same edge; busy stays 0.
- WRITE, fill==DEPTH: data dropped, ovf<=1, fill unchanged.
- CLEAR: fill<=0, ovf<=0, all result outputs <=0. Completes in 1 cycle.
- NOP: no effect.
- SEARCH accepted at edge E0:
  - key<=inp; gt/eq/lt counts and eq_found cleared; state SCAN; busy=1.
  - Entry k (0..fill-1) is compared at edge E0+1+k.
  - Counters increment as each entry is compared. eq_idx is captured on the first equality only.
- FSM states IDLE, SCAN, DONE:
  - IDLE->SCAN on an accepted search.
  - SCAN->DONE after the last entry. If fill==0, SCAN lasts exactly one cycle and compares nothing.
  - DONE->IDLE after one cycle.
- busy is high for max(fill,1) cycles after E0.
- done=1 for exactly the following cycle. busy=0 during done, so a new command can be accepted in that cycle.
- fill cannot change during SCAN, because commands are blocked while busy.
- Result outputs hold their values until the next accepted SEARCH, CLEAR or rst.
- Invariant at done: gt_cnt+eq_cnt+lt_cnt == fill at search start.
- eq_idx=0 whenever eq_found=0.

Optional Feature:
- Macro LD_PARITY_EN.
- Defined:
  - par_key<=^key, registered with the key.
  - par_all holds the XOR-reduction of all bits of entries 0..fill-1. It updates on every accepted write and clears on CLEAR/rst.
- Undefined: par_key and par_all are tied to 0 and no parity logic is built.

Test Plan:
- Defaults, after rst: write 3,10,21,10,31; search key 10.
  - busy for 5 cycles, then done for 1 cycle.
  - gt_cnt=2, eq_cnt=2, lt_cnt=1, eq_found=1, eq_idx=1, fill=5.
- Empty search after rst: search key 7.
  - busy for 1 cycle, then done.
  - All counts 0, eq_found=0, eq_idx=0.
- Overflow: write 9 words (values 0..8).
  - fill=8, full=1, ovf=1, entry 7 holds 7.
  - Then CLEAR: fill=0, ovf=0, full=0.
- Busy lockout: 8 entries of 31, search key 31; pulse start with op=01 on cycle 3 of the scan.
  - Write is ignored, fill stays 8.
  - eq_cnt=8, eq_idx=0, done on cycle 9.
- Reset mid-search: rst asserted on cycle 2 of an 8-entry scan.
  - Next cycle: busy=0, done never pulses, fill=0, all results 0.
- LD_PARITY_EN: write 5'b10101 and 5'b00011, search key 5'b11111.
  - par_all=1, par_key=1.
  - Without the macro, both outputs read 0.

Source files
------------

// File: rtl/ld_search_bank.sv
// ============================================================================
// ld_search_bank : word store with sequential key search (gt/eq/lt, first match)
// Optional parity outputs enabled by macro LD_PARITY_EN.     Rev 1.0
// ============================================================================
`default_nettype none

module ld_search_bank #(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inp,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    fill,
  output logic             full,
  output logic             ovf,
  output logic [CW-1:0]    gt_cnt,
  output logic [CW-1:0]    eq_cnt,
  output logic [CW-1:0]    lt_cnt,
  output logic             eq_found,
  output logic [IW-1:0]    eq_idx,
  output logic             par_key,
  output logic             par_all
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_SEARCH = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    fill_q, fill_d, gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic             ovf_q, ovf_d, found_q, found_d;
  logic [IW-1:0]    idx_q, idx_d, eq_idx_q, eq_idx_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [WIDTH-1:0] cur_w;
  logic             busy_w, done_w, accept_w, room_w, cmp_w, last_w;
  logic             wr_w, srch_w, clr_w;

  assign accept_w = start && !busy_w;
  assign wr_w     = accept_w && (op == OP_WRITE);
  assign srch_w   = accept_w && (op == OP_SEARCH);
  assign clr_w    = accept_w && (op == OP_CLEAR);
  assign room_w   = (fill_q < CW'(DEPTH));
  assign cur_w    = mem_q[idx_q];
  assign cmp_w    = (state_q == S_SCAN) && (fill_q != '0);
  // An empty bank still spends one SCAN cycle so busy is never zero-length.
  assign last_w   = (state_q == S_SCAN) &&
                    ((fill_q == '0) || ((CW'(idx_q) + CW'(1)) == fill_q));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (srch_w) state_d = S_SCAN;
      S_SCAN:  if (last_w) state_d = S_DONE;
      S_DONE:  state_d = srch_w ? S_SCAN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_w = 1'b0;
    done_w = 1'b0;
    case (state_q)
      S_SCAN:  busy_w = 1'b1;
      S_DONE:  done_w = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    found_d  = found_q;
    eq_idx_d = eq_idx_q;
    idx_d    = idx_q;
    key_d    = key_q;
    if (wr_w) begin
      if (room_w) fill_d = fill_q + CW'(1);
      else        ovf_d  = 1'b1;
    end
    if (srch_w || clr_w) begin
      gt_d     = '0;
      eq_d     = '0;
      lt_d     = '0;
      found_d  = 1'b0;
      eq_idx_d = '0;
    end
    if (srch_w) begin
      key_d = inp;
      idx_d = '0;
    end
    if (clr_w) begin
      fill_d = '0;
      ovf_d  = 1'b0;
    end
    if (cmp_w) begin
      idx_d = idx_q + IW'(1);
      if (cur_w > key_q)      gt_d = gt_q + CW'(1);
      else if (cur_w < key_q) lt_d = lt_q + CW'(1);
      else begin
        eq_d = eq_q + CW'(1);
        if (!found_q) begin
          found_d  = 1'b1;
          eq_idx_d = idx_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q   <= '0;
      ovf_q    <= 1'b0;
      gt_q     <= '0;
      eq_q     <= '0;
      lt_q     <= '0;
      found_q  <= 1'b0;
      eq_idx_q <= '0;
      idx_q    <= '0;
      key_q    <= '0;
    end else begin
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      found_q  <= found_d;
      eq_idx_q <= eq_idx_d;
      idx_q    <= idx_d;
      key_q    <= key_d;
    end
  end

  // Storage is deliberately left unreset; fill alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_w && room_w) mem_q[fill_q[IW-1:0]] <= inp;
  end

`ifdef LD_PARITY_EN
  logic par_key_q, par_all_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_key_q <= 1'b0;
      par_all_q <= 1'b0;
    end else begin
      if (srch_w) par_key_q <= ^inp;
      if (wr_w && room_w) par_all_q <= par_all_q ^ (^inp);
      else if (clr_w)     par_all_q <= 1'b0;
    end
  end

  assign par_key = par_key_q;
  assign par_all = par_all_q;
`else
  assign par_key = 1'b0;
  assign par_all = 1'b0;
`endif

  assign busy     = busy_w;
  assign done     = done_w;
  assign fill     = fill_q;
  assign full     = (fill_q == CW'(DEPTH));
  assign ovf      = ovf_q;
  assign gt_cnt   = gt_q;
  assign eq_cnt   = eq_q;
  assign lt_cnt   = lt_q;
  assign eq_found = found_q;
  assign eq_idx   = eq_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_ld_search_bank.sv
// ============================================================================
// tb_ld_search_bank : directed vector table plus hand sequences for ld_search_bank
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ld_search_bank;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] op;
  logic [4:0] inp;
  logic       busy, done, full, ovf, eq_found, par_key, par_all;
  logic [3:0] fill, gt_cnt, eq_cnt, lt_cnt;
  logic [2:0] eq_idx;

  int checks = 0;
  int errors = 0;

  ld_search_bank #(.WIDTH(5), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .inp(inp),
    .busy(busy), .done(done), .fill(fill), .full(full), .ovf(ovf),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
    .eq_found(eq_found), .eq_idx(eq_idx),
    .par_key(par_key), .par_all(par_all)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [4:0] inp;
    int         fill;
    int         full;
    int         ovf;
    int         busy;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] o, input logic [4:0] d);
    start = 1'b1; op = o; inp = d;
    step();
    start = 1'b0; op = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; op = 2'd0;
    step();
    rst = 1'b0;
  endtask

  task automatic search(input string tag, input logic [4:0] key, input int exp_busy);
    int n;
    start = 1'b1; op = 2'd2; inp = key;
    step();
    start = 1'b0; op = 2'd0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    chk({tag, "_busy_cycles"}, n, exp_busy);
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic results(input string tag, input int g, input int e, input int l,
                         input int f, input int ix);
    chk({tag, "_gt"}, gt_cnt, g);
    chk({tag, "_eq"}, eq_cnt, e);
    chk({tag, "_lt"}, lt_cnt, l);
    chk({tag, "_found"}, eq_found, f);
    chk({tag, "_idx"}, eq_idx, ix);
  endtask

  initial begin
    int n, seen;
    rst = 1'b0; start = 1'b0; op = 2'd0; inp = 5'd0;

    vt[0] = '{1'b1, 1'b0, 2'd0, 5'd0, 0, 0, 0, 0};
    vt[1] = '{1'b0, 1'b1, 2'd0, 5'd9, 0, 0, 0, 0};
    vt[2] = '{1'b0, 1'b0, 2'd1, 5'd5, 0, 0, 0, 0};
    for (int k = 0; k < 8; k++)
      vt[3+k] = '{1'b0, 1'b1, 2'd1, 5'(k), k + 1, (k == 7) ? 1 : 0, 0, 0};
    vt[11] = '{1'b0, 1'b1, 2'd1, 5'd8, 8, 1, 1, 0};
    vt[12] = '{1'b0, 1'b0, 2'd1, 5'd8, 8, 1, 1, 0};

    step();
    for (int i = 0; i < 13; i++) begin
      rst = vt[i].rst; start = vt[i].start; op = vt[i].op; inp = vt[i].inp;
      step();
      chk($sformatf("vec%0d_fill", i), fill, vt[i].fill);
      chk($sformatf("vec%0d_full", i), full, vt[i].full);
      chk($sformatf("vec%0d_ovf", i),  ovf,  vt[i].ovf);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
    end
    rst = 1'b0; start = 1'b0;
    chk("reset_done", done, 0);

    // Overflow left entries 0..7 = 0..7; key 7 hits only the last entry.
    search("ovf_srch", 5'd7, 8);
    results("ovf_srch", 0, 1, 7, 1, 7);
    cmd(2'd3, 5'd0);
    chk("clr_fill", fill, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_full", full, 0);
    results("clr", 0, 0, 0, 0, 0);

    do_reset();
    cmd(2'd1, 5'd3);  cmd(2'd1, 5'd10); cmd(2'd1, 5'd21);
    cmd(2'd1, 5'd10); cmd(2'd1, 5'd31);
    search("t1", 5'd10, 5);
    results("t1", 2, 2, 1, 1, 1);
    chk("t1_fill", fill, 5);
    step();
    chk("t1_done_clear", done, 0);
    chk("t1_eq_hold", eq_cnt, 2);
    chk("t1_idx_hold", eq_idx, 1);

    do_reset();
    search("empty", 5'd7, 1);
    results("empty", 0, 0, 0, 0, 0);
    step();
    chk("empty_done_clear", done, 0);

    do_reset();
    for (int k = 0; k < 8; k++) cmd(2'd1, 5'd31);
    start = 1'b1; op = 2'd2; inp = 5'd31;
    step();
    n = 0;
    while (busy && n < 40) begin
      if (n == 2) begin start = 1'b1; op = 2'd1; inp = 5'd4; end
      else        begin start = 1'b0; op = 2'd0; end
      n++;
      step();
    end
    start = 1'b0; op = 2'd0;
    chk("lock_busy_cycles", n, 8);
    chk("lock_done", done, 1);
    chk("lock_fill", fill, 8);
    chk("lock_ovf", ovf, 0);
    results("lock", 0, 8, 0, 1, 0);
    step();

    start = 1'b1; op = 2'd2; inp = 5'd31;
    step();
    start = 1'b0; op = 2'd0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_fill", fill, 0);
    results("rstmid", 0, 0, 0, 0, 0);
    seen = 0;
    repeat (10) begin
      if (done) seen++;
      step();
    end
    chk("rstmid_no_done", seen, 0);

    do_reset();
    cmd(2'd1, 5'b10101);
    cmd(2'd1, 5'b00011);
    search("par", 5'b11111, 2);
`ifdef LD_PARITY_EN
    chk("par_all", par_all, 1);
    chk("par_key", par_key, 1);
`else
    chk("par_all", par_all, 0);
    chk("par_key", par_key, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
